// File: rtl/instruction_fetch_unit.sv
// Fetch stage (RESET_WAIT -> FETCH -> EXECUTE); decoded outputs valid the cycle after imem_ready is sampled.
// Backpressure: imem may hold off imem_ready indefinitely; stall freezes EXECUTE until released.
module instruction_fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [31:0]           imem_rdata,
  input  logic                  stall,
  input  logic [1:0]            next_pc_selector,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] target_addr,
  output logic                  instr_valid,
  output logic [31:0]           instruction,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [ADDR_WIDTH-1:0] pc_plus_4,
  output logic                  r_type,
  output logic                  i_type_lw,
  output logic                  i_type_addi,
  output logic                  i_type_jalr,
  output logic                  s_type,
  output logic                  sb_type,
  output logic                  u_type_auipc,
  output logic                  u_type_lui,
  output logic                  uj_type,
  output logic [2:0]            func_3,
  output logic                  func_7_bit_6,
  output logic                  illegal_instr
);

  typedef enum logic [1:0] {S_RESET_WAIT, S_FETCH, S_EXECUTE} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [ADDR_WIDTH-1:0] w_pc_plus_4;
  logic [ADDR_WIDTH-1:0] w_next_pc;
  logic [31:0]           r_instr;
  logic [8:0]            r_dec;
  logic [8:0]            w_dec;
  logic                  r_illegal;
  logic                  w_illegal;
  logic                  w_take_target;
  logic                  w_accept;
  logic                  w_retire;
  logic                  w_valid;

  assign w_valid  = (r_state == S_EXECUTE);
  assign w_accept = (r_state == S_FETCH) && imem_ready;
  assign w_retire = w_valid && !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_RESET_WAIT;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RESET_WAIT: w_state_nxt = S_FETCH;
      S_FETCH:      if (imem_ready) w_state_nxt = S_EXECUTE;
      S_EXECUTE:    if (!stall) w_state_nxt = S_FETCH;
      default:      w_state_nxt = S_RESET_WAIT;
    endcase
  end

  // Bit order of w_dec matches the strobe concatenation on the outputs below.
  always_comb begin
    w_dec     = '0;
    w_illegal = 1'b0;
    case (imem_rdata[6:0])
      7'b0110011: w_dec[0] = 1'b1;
      7'b0000011: w_dec[1] = 1'b1;
      7'b0010011: w_dec[2] = 1'b1;
      7'b1100111: w_dec[3] = 1'b1;
      7'b0100011: w_dec[4] = 1'b1;
      7'b1100011: w_dec[5] = 1'b1;
      7'b0010111: w_dec[6] = 1'b1;
      7'b0110111: w_dec[7] = 1'b1;
      7'b1101111: w_dec[8] = 1'b1;
      default:    w_illegal = 1'b1;
    endcase
  end

  // Illegal opcodes fall through sequentially; masking [1:0] also covers jalr's bit-0 clear.
  assign w_pc_plus_4   = r_pc + ADDR_WIDTH'(4);
  assign w_take_target = !r_illegal &&
                         ((next_pc_selector == 2'b10) || (next_pc_selector == 2'b11) ||
                          ((next_pc_selector == 2'b01) && branch_taken));
  assign w_next_pc     = (w_take_target ? target_addr : w_pc_plus_4) & ~ADDR_WIDTH'(3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc      <= RESET_PC;
      r_instr   <= 32'h0000_0013;
      r_dec     <= '0;
      r_illegal <= 1'b0;
    end else begin
      if (w_accept) begin
        r_instr   <= imem_rdata;
        r_dec     <= w_dec;
        r_illegal <= w_illegal;
      end
      if (w_retire) r_pc <= w_next_pc;
    end
  end

  assign imem_req    = (r_state == S_FETCH);
  assign imem_addr   = r_pc;
  assign instr_valid = w_valid;
  assign instruction = r_instr;
  assign pc          = r_pc;
  assign pc_plus_4   = w_pc_plus_4;

  // control_decoder must see an all-zero vector whenever nothing is executing.
  assign {uj_type, u_type_lui, u_type_auipc, sb_type, s_type,
          i_type_jalr, i_type_addi, i_type_lw, r_type} = r_dec & {9{w_valid}};
  assign illegal_instr = r_illegal & w_valid;
  assign func_3        = r_instr[14:12] & {3{w_valid}};
  assign func_7_bit_6  = r_instr[30] & w_valid;

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Multi-cycle fetch stage that produces the one-hot instruction-type strobes, func_3 and func_7_bit_6 consumed by control_decoder.
- Owns the PC and runs a request/ready handshake with instruction memory.
- Latches each fetched word and presents it for exactly one execute cycle, or longer while stalled.
- Computes the next PC from the next_pc_selector returned by control_decoder.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
ADDR_WIDTH, 32, width of pc, imem_addr and target buses.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  reset, asynchronous, active-low.
imem_req  output  1  fetch request to instruction memory.
imem_addr  output  ADDR_WIDTH  fetch address; equals pc while imem_req=1.
imem_ready  input  1  imem_rdata valid this cycle; sampled only while imem_req=1.
imem_rdata  input  32  fetched instruction word.
stall  input  1  holds the current instruction in EXECUTE.
next_pc_selector  input  2  from control_decoder: 00 seq, 01 branch, 10 jal, 11 jalr.
branch_taken  input  1  branch comparator result; used only when selector=01.
target_addr  input  ADDR_WIDTH  ALU-computed jump/branch target.
instr_valid  output  1  instruction and type outputs are valid; high in EXECUTE only.
instruction  output  32  latched instruction word.
pc  output  ADDR_WIDTH  address of the latched instruction.
pc_plus_4  output  ADDR_WIDTH  pc + 4, modulo 2^ADDR_WIDTH.
r_type, i_type_lw, i_type_addi, i_type_jalr, s_type, sb_type, u_type_auipc, u_type_lui, uj_type  output  1 each  one-hot type strobes.
func_3  output  3  instruction[14:12].
func_7_bit_6  output  1  instruction[30].
illegal_instr  output  1  opcode not in the supported set.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - State = RESET_WAIT; pc = RESET_PC.
  - instruction = 32'h0000_0013 (NOP).
  - imem_req, instr_valid, all type strobes and illegal_instr = 0; func_3 = 0; func_7_bit_6 = 0.
- FSM states: RESET_WAIT, FETCH, EXECUTE.
- RESET_WAIT: one cycle, then go to FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ready=1: latch imem_rdata into instruction, register the decoded outputs, go to EXECUTE.
  - Otherwise stay in FETCH; there is no timeout.
- Fetch latency: instr_valid rises on the cycle after imem_ready is sampled high.
- EXECUTE:
  - instr_valid=1.
  - If stall=1: hold every output and pc unchanged.
  - If stall=0: update pc and go to FETCH.
  - One instruction completes per fetch round trip (minimum 2 cycles per instruction).
- Type decode, registered from imem_rdata[6:0]:
  - 0110011 → r_type
  - 0000011 → i_type_lw
  - 0010011 → i_type_addi
  - 1100111 → i_type_jalr
  - 0100011 → s_type
  - 1100011 → sb_type
  - 0010111 → u_type_auipc
  - 0110111 → u_type_lui
  - 1101111 → uj_type
- At most one strobe is high at any time.
- Any other opcode: all strobes 0 and illegal_instr=1. The instruction is treated as sequential and pc advances by 4.
- Next PC, evaluated on leaving EXECUTE:
  - 00 → pc+4.
  - 01 → target_addr if branch_taken, else pc+4.
  - 10 → target_addr.
  - 11 → target_addr with bit 0 cleared.
  - In every case bits [1:0] of the new pc are forced to 0 (word-aligned imem).
- Wrap-around: pc+4 at 32'hFFFF_FFFC wraps to 32'h0000_0000 with no flag.
- Outside EXECUTE, next_pc_selector, branch_taken and target_addr are ignored.
- stall is ignored in FETCH and RESET_WAIT.
- Reset mid-fetch: imem_req drops immediately (asynchronous); any imem_ready that arrives later is ignored until the FSM is back in FETCH.
- Outputs in FETCH: the type strobes, func_3 and func_7_bit_6 are driven to 0 whenever instr_valid=0, so control_decoder sees an all-zero vector.

Test Plan:
- Reset release, imem_ready tied 1: imem_req rises 1 cycle after release with imem_addr=0. Word 32'h00500093 gives instr_valid=1, i_type_addi=1, func_3=000, pc=0.
- Sequential stream 0x00208033 (add), 0x40208033 (sub): r_type both times, func_7_bit_6 = 0 then 1; pc = 0 then 4.
- sb_type at pc=0x10, selector=01, target_addr=0x40: branch_taken=1 → next imem_addr=0x40; branch_taken=0 → next imem_addr=0x14.
- jalr with selector=11, target_addr=0x0000_0123 → next imem_addr=0x0000_0120. jal with selector=10, target_addr=0x80 → next imem_addr=0x80.
- imem_ready held low for 5 cycles, then stall=1 for 3 cycles in EXECUTE: imem_req held for 6 cycles total; outputs frozen during the stall; pc updates only once stall=0.
- Opcode 0x7F → illegal_instr=1, all strobes 0, next pc=pc+4. pc=0xFFFF_FFFC with selector=00 → next imem_addr=0. rst_n pulsed low mid-FETCH → imem_req=0 immediately, pc=RESET_PC.
